ft245_rx_deframer: RTL

Frame parser between the FT245 FIFO interface receive side and the modulator sample path. Hunts for a sync byte in the received byte stream and reads a length byte. Packs the payload bytes into 16-bit samples, MSB first, and streams them out with valid/ready. Checks a trailing XOR checksum and flags frame completion or error.

---
 rtl/ft245_rx_deframer_if.sv | 36 +++
 rtl/ft245_rx_deframer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ft245_rx_deframer_if.sv
// rtl/ft245_rx_deframer_if.sv - byte-in / sample-out bundle of the FT245 receive deframer
//
// Purpose: groups the receive byte stream, the packed sample stream and the
// frame status pulses seen between the FT245 receive side, the deframer and
// the modulator sample path.
// Signals:
//   in_data[7:0]      received byte
//   in_valid          in_data holds a byte
//   in_ready          deframer accepts a byte this cycle
//   sample_data[15:0] packed sample {first byte, second byte}
//   sample_valid      sample_data is valid
//   sample_ready      downstream takes the sample this cycle
//   frame_done        one-cycle pulse, checksum matched
//   frame_err         one-cycle pulse, checksum mismatch, bad length or timeout
// Modports: slave = deframer side, master = byte source / sample sink side.

interface ft245_rx_deframer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_done;
  logic        frame_err;

  modport slave (
    input  in_data, in_valid, sample_ready,
    output in_ready, sample_data, sample_valid, frame_done, frame_err
  );

  modport master (
    output in_data, in_valid, sample_ready,
    input  in_ready, sample_data, sample_valid, frame_done, frame_err
  );
endinterface

// File: rtl/ft245_rx_deframer.sv
// rtl/ft245_rx_deframer.sv - FT245 receive frame parser packing payload into 16-bit samples
//
// Purpose: hunts for SYNC_BYTE, reads a length byte, packs LEN payload bytes
// MSB first into 16-bit samples streamed out with valid/ready, then checks a
// trailing XOR checksum (LEN ^ payload bytes) and pulses frame_done or
// frame_err. A frame stalled mid-way for TIMEOUT_CYCLES idle cycles is
// abandoned with frame_err.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ft245_rx_deframer_if.slave (byte input, sample output, status pulses)

module ft245_rx_deframer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst,
  ft245_rx_deframer_if.slave    bus
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  // The abort fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_HI, S_LO, S_CHK} state_t;

  state_t        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   sd_q, sd_d;
  logic          sv_q, sv_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;

  // Input is held off whenever the output register is full and not draining,
  // regardless of state, so no accepted byte can ever overwrite a sample.
  assign bus.in_ready     = !sv_q || bus.sample_ready;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.sample_data  = sd_q;
  assign bus.sample_valid = sv_q;
  assign bus.frame_done   = done_q;
  assign bus.frame_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      rem_q   <= '0;
      chk_q   <= '0;
      hi_q    <= '0;
      tcnt_q  <= '0;
      sd_q    <= '0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      tcnt_q  <= tcnt_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    tcnt_d  = tcnt_q;
    sd_d    = sd_q;
    // A delivered sample empties the register unless an LO byte reloads it below.
    sv_d    = sv_q && !bus.sample_ready;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (accept) begin
      tcnt_d = '0;
      case (state_q)
        S_HUNT: begin
          if (bus.in_data == SYNC_BYTE) state_d = S_LEN;
        end
        S_LEN: begin
          if (bus.in_data == 8'd0 || bus.in_data[0] || bus.in_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            rem_d   = bus.in_data;
            chk_d   = bus.in_data;
            state_d = S_HI;
          end
        end
        S_HI: begin
          hi_d    = bus.in_data;
          chk_d   = chk_q ^ bus.in_data;
          state_d = S_LO;
        end
        S_LO: begin
          sd_d    = {hi_q, bus.in_data};
          sv_d    = 1'b1;
          chk_d   = chk_q ^ bus.in_data;
          rem_d   = rem_q - 8'd2;
          state_d = (rem_q == 8'd2) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (bus.in_data == chk_q) done_d = 1'b1;
          else                      err_d  = 1'b1;
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end else if (state_q == S_HUNT) begin
      tcnt_d = '0;
    end else if (tcnt_q == T_LAST) begin
      // Abandon the frame; a sample already in the output register still drains.
      tcnt_d  = '0;
      err_d   = 1'b1;
      state_d = S_HUNT;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

endmodule
